mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory/cache bus between the instruction-fetch port and the memory-access (MA) stage data port. Data requests win by default; a streak counter stops fetch from starving. A fetch flush drops an in-flight fetch response after a branch redirect. o_ma_done drives the hazard unit's MA cache-ready input.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_DATA_STREAK, 4, max consecutive data grants while fetch is pending (>=1)

Ports:
i_aclk  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_if_req  in  1  fetch request; held with i_if_addr stable until o_if_done or i_if_flush
i_if_addr  in  ADDR_W  fetch address
i_if_flush  in  1  one-cycle pulse: branch redirect, discard outstanding fetch
o_if_done  out  1  fetch complete, combinational from i_mem_ack
o_if_rdata  out  DATA_W  fetch data, valid with o_if_done
i_ma_req  in  1  data request; held with fields stable until o_ma_done
i_ma_we  in  1  1=write, 0=read
i_ma_be  in  DATA_W/8  byte enables
i_ma_addr  in  ADDR_W  data address
i_ma_wdata  in  DATA_W  write data
o_ma_done  out  1  data access complete, combinational from i_mem_ack
o_ma_rdata  out  DATA_W  read data, valid with o_ma_done
o_mem_req  out  1  bus request, registered
o_mem_we  out  1  bus write enable, registered
o_mem_be  out  DATA_W/8  bus byte enables, registered
o_mem_addr  out  ADDR_W  bus address, registered
o_mem_wdata  out  DATA_W  bus write data, registered
i_mem_ack  in  1  bus completion; only meaningful while o_mem_req=1
i_mem_rdata  in  DATA_W  bus read data, valid with i_mem_ack

Behaviour:
- Reset (synchronous, i_reset=1 at a rising edge): state IDLE, drop flag 0, streak 0.
  - o_mem_req, o_mem_we: 0; o_mem_be, o_mem_addr, o_mem_wdata: 0.
  - o_if_done, o_ma_done: 0 (state IDLE implies this).
- States:
  - IDLE: arbitrate. Grant registers the chosen request's fields onto o_mem_*; o_mem_req=1 from the next cycle.
    - Data granted -> DATA_BUSY. Fetch granted -> IF_BUSY. No request -> stay.
  - IF_BUSY / DATA_BUSY: hold o_mem_* stable until i_mem_ack.
    - On ack: done pulse in the same cycle; o_mem_req=0 and state=IDLE next cycle.
- Latency: request seen in IDLE at cycle N -> o_mem_req high at N+1 -> done in the ack cycle (earliest N+1).
  - Minimum issue interval: 2 cycles per transaction (1 IDLE + >=1 BUSY).
  - Requester updates its request the cycle after done; arbiter samples it in IDLE that cycle.
- Arbitration in IDLE, with fetch eligible = i_if_req & ~i_if_flush:
  - Both requesting and streak==MAX_DATA_STREAK -> fetch.
  - Otherwise, data requesting -> data.
  - Otherwise, fetch eligible -> fetch.
- Streak counter:
  - Increments on a data grant while fetch is eligible; saturates at MAX_DATA_STREAK.
  - Clears on a fetch grant, or in any IDLE cycle with fetch not eligible.
  - Width: $clog2(MAX_DATA_STREAK+1).
- Flush:
  - i_if_flush in IF_BUSY, or in the ack cycle of IF_BUSY -> set drop flag; transaction still completes on the bus; o_if_done forced 0 for it. Drop flag clears on that ack.
  - Flush in IDLE -> that cycle's fetch request is ineligible.
  - Flush in DATA_BUSY -> no effect.
- Done gating:
  - o_if_done = ack & IF_BUSY & ~drop & ~i_if_flush.
  - o_ma_done = ack & DATA_BUSY.
  - o_*_rdata = i_mem_rdata (passthrough, valid only with done).
- i_mem_ack while o_mem_req=0 is ignored, including the first cycle after reset.
- Reset mid-transaction: state returns to IDLE, o_mem_req=0 next cycle, no done pulse. The memory is reset by the same signal.
- o_mem_we/be/wdata for fetch: we=0, be=all ones, wdata=0.

Decomposition:
- multicore_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_IF_BUSY, ARB_DATA_BUSY}
  - constant ARB_MAX_DATA_STREAK=4, used as the parameter default
- No sub-module. FSM, streak counter and drop flag stay in one always_ff plus one always_comb.

Test Plan:
- Fetch only, addr 0x100, ack 3 cycles after o_mem_req rises, rdata 0x00000013 -> o_mem_addr=0x100, we=0, be=0xF held for 3 cycles; o_if_done=1 with 0x00000013 in the ack cycle only.
- i_if_req and i_ma_req (read 0x2000) rise together, ack latency 1 -> data transaction first (o_ma_done), IDLE cycle, then fetch transaction; o_if_done 2 cycles after o_ma_done.
- i_ma_req held continuously with new addresses, fetch pending, MAX_DATA_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- Fetch in IF_BUSY, i_if_flush pulsed before ack -> o_if_done stays 0; bus ack completes; next IDLE grants the new fetch address 0x240.
- Data write, be=0011, wdata 0xDEADBEEF, ack delayed 5 cycles -> o_mem_we/be/addr/wdata stable all 5 cycles; o_ma_done one cycle.
- i_reset asserted in DATA_BUSY, stray i_mem_ack the next cycle -> o_mem_req=0 after the reset edge; no o_ma_done; state IDLE; streak 0.

Source files
------------

// File: rtl/multicore_pkg.sv
// rtl/multicore_pkg.sv - shared types and constants for the memory port arbiter
// Contents:
//   arb_state_t          : arbiter FSM states
//   ARB_MAX_DATA_STREAK  : default cap on consecutive data grants while fetch waits
package multicore_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_IF_BUSY   = 2'd1,
        ARB_DATA_BUSY = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between the fetch port and the MA data port
// Ports:
//   i_aclk, i_reset          : clock, synchronous active-high reset
//   i_if_req/addr/flush      : fetch request, address, branch-redirect flush pulse
//   o_if_done/rdata          : fetch completion and data (combinational from i_mem_ack)
//   i_ma_req/we/be/addr/wdata: data-port request and fields
//   o_ma_done/rdata          : data completion and read data (combinational from i_mem_ack)
//   o_mem_req/we/be/addr/wdata : registered bus request and fields
//   i_mem_ack/rdata          : bus completion and read data
module mem_port_arbiter
    import multicore_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = ARB_MAX_DATA_STREAK
) (
    input  logic                  i_aclk,
    input  logic                  i_reset,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    input  logic                  i_if_flush,
    output logic                  o_if_done,
    output logic [DATA_W-1:0]     o_if_rdata,
    input  logic                  i_ma_req,
    input  logic                  i_ma_we,
    input  logic [DATA_W/8-1:0]   i_ma_be,
    input  logic [ADDR_W-1:0]     i_ma_addr,
    input  logic [DATA_W-1:0]     i_ma_wdata,
    output logic                  o_ma_done,
    output logic [DATA_W-1:0]     o_ma_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_W/8-1:0]   o_mem_be,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    arb_state_t            r_state;
    logic                  r_drop;
    logic [SW-1:0]         r_streak;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_W/8-1:0]   r_mem_be;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;

    logic                  w_if_elig;
    logic                  w_streak_max;
    logic                  w_grant_if;
    logic                  w_grant_data;

    always_comb begin
        // A flush in the same cycle makes the (stale) fetch address ineligible.
        w_if_elig    = i_if_req & ~i_if_flush;
        w_streak_max = (r_streak == SW'(MAX_DATA_STREAK));
        w_grant_if   = (r_state == ARB_IDLE) & w_if_elig & (~i_ma_req | w_streak_max);
        w_grant_data = (r_state == ARB_IDLE) & i_ma_req & ~w_grant_if;
        // A flush arriving in the ack cycle itself must also suppress the done.
        o_if_done    = i_mem_ack & (r_state == ARB_IF_BUSY) & ~r_drop & ~i_if_flush;
        o_ma_done    = i_mem_ack & (r_state == ARB_DATA_BUSY);
        o_if_rdata   = i_mem_rdata;
        o_ma_rdata   = i_mem_rdata;
    end

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            r_state     <= ARB_IDLE;
            r_drop      <= 1'b0;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_data) begin
                        r_state     <= ARB_DATA_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_ma_we;
                        r_mem_be    <= i_ma_be;
                        r_mem_addr  <= i_ma_addr;
                        r_mem_wdata <= i_ma_wdata;
                        // Only count grants that actually made fetch wait.
                        if (!w_if_elig)
                            r_streak <= '0;
                        else if (!w_streak_max)
                            r_streak <= r_streak + SW'(1);
                    end else if (w_grant_if) begin
                        r_state     <= ARB_IF_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= '0;
                        r_streak    <= '0;
                        r_drop      <= 1'b0;
                    end else begin
                        r_streak <= '0;
                    end
                end
                ARB_IF_BUSY: begin
                    if (i_mem_ack) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                    end else if (i_if_flush) begin
                        // Bus transaction still runs to completion; only the done is hidden.
                        r_drop <= 1'b1;
                    end
                end
                ARB_DATA_BUSY: begin
                    if (i_mem_ack) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import multicore_pkg::*;

    logic        i_aclk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_if_flush;
    logic        o_if_done;
    logic [31:0] o_if_rdata;
    logic        i_ma_req;
    logic        i_ma_we;
    logic [3:0]  i_ma_be;
    logic [31:0] i_ma_addr;
    logic [31:0] i_ma_wdata;
    logic        o_ma_done;
    logic [31:0] o_ma_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_aclk = ~i_aclk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
        .i_aclk(i_aclk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_done(o_if_done), .o_if_rdata(o_if_rdata),
        .i_ma_req(i_ma_req), .i_ma_we(i_ma_we), .i_ma_be(i_ma_be),
        .i_ma_addr(i_ma_addr), .i_ma_wdata(i_ma_wdata),
        .o_ma_done(o_ma_done), .o_ma_rdata(o_ma_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance negedges until o_mem_req is seen, bounded.
    task automatic wait_req(input string name);
        int i;
        for (i = 0; i < 20 && o_mem_req !== 1'b1; i++) @(negedge i_aclk);
        chk(name, {31'd0, o_mem_req}, 32'd1);
    endtask

    task automatic idle_inputs();
        i_if_req = 0; i_if_addr = 0; i_if_flush = 0;
        i_ma_req = 0; i_ma_we = 0; i_ma_be = 0; i_ma_addr = 0; i_ma_wdata = 0;
        i_mem_ack = 0; i_mem_rdata = 0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h100,  32'h0,        3, 32'h00000013, 1'b0, 4'hF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h3000, 32'hDEADBEEF, 5, 32'h0,        1'b1, 4'h3, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h2004, 32'h0,        1, 32'hCAFEF00D, 1'b0, 4'hF, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h104,  32'h0,        2, 32'h00100093, 1'b0, 4'hF, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 4'hC, 32'h3004, 32'h12345678, 2, 32'h0,        1'b1, 4'hC, 32'h12345678};

        idle_inputs();
        i_reset = 1;
        @(posedge i_aclk); @(posedge i_aclk);
        @(negedge i_aclk);
        i_reset = 0;

        // Reset state; a stray ack with no transaction must be ignored.
        chk("rst_mem_req",   {31'd0, o_mem_req}, 32'd0);
        chk("rst_mem_we",    {31'd0, o_mem_we},  32'd0);
        chk("rst_mem_be",    {28'd0, o_mem_be},  32'd0);
        chk("rst_mem_addr",  o_mem_addr,         32'd0);
        chk("rst_mem_wdata", o_mem_wdata,        32'd0);
        i_mem_ack = 1;
        #1;
        chk("rst_if_done", {31'd0, o_if_done}, 32'd0);
        chk("rst_ma_done", {31'd0, o_ma_done}, 32'd0);
        @(negedge i_aclk);
        i_mem_ack = 0;
        chk("rst_stray_ack_req", {31'd0, o_mem_req}, 32'd0);

        // Table of single transactions.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].is_data) begin
                i_ma_req = 1; i_ma_we = vecs[v].we; i_ma_be = vecs[v].be;
                i_ma_addr = vecs[v].addr; i_ma_wdata = vecs[v].wdata;
            end else begin
                i_if_req = 1; i_if_addr = vecs[v].addr;
            end
            @(negedge i_aclk);
            wait_req($sformatf("v%0d_req", v));
            for (int k = 0; k < vecs[v].delay; k++) begin
                chk($sformatf("v%0d_addr", v),  o_mem_addr,               vecs[v].addr);
                chk($sformatf("v%0d_we", v),    {31'd0, o_mem_we},        {31'd0, vecs[v].exp_we});
                chk($sformatf("v%0d_be", v),    {28'd0, o_mem_be},        {28'd0, vecs[v].exp_be});
                chk($sformatf("v%0d_wdata", v), o_mem_wdata,              vecs[v].exp_wdata);
                if (k == vecs[v].delay - 1) begin
                    i_mem_ack = 1; i_mem_rdata = vecs[v].rdata;
                end
                #1;
                chk($sformatf("v%0d_if_done_k%0d", v, k), {31'd0, o_if_done},
                    {31'd0, (k == vecs[v].delay - 1) && !vecs[v].is_data});
                chk($sformatf("v%0d_ma_done_k%0d", v, k), {31'd0, o_ma_done},
                    {31'd0, (k == vecs[v].delay - 1) && vecs[v].is_data});
                if (k == vecs[v].delay - 1) begin
                    if (vecs[v].is_data) chk($sformatf("v%0d_ma_rdata", v), o_ma_rdata, vecs[v].rdata);
                    else                 chk($sformatf("v%0d_if_rdata", v), o_if_rdata, vecs[v].rdata);
                end
                @(negedge i_aclk);
            end
            idle_inputs();
            chk($sformatf("v%0d_req_drop", v), {31'd0, o_mem_req}, 32'd0);
        end

        // Simultaneous requests: data first, one IDLE cycle, then fetch.
        i_if_req = 1; i_if_addr = 32'h180;
        i_ma_req = 1; i_ma_addr = 32'h2000; i_ma_be = 4'hF;
        @(negedge i_aclk);
        chk("both_first_addr", o_mem_addr, 32'h2000);
        i_mem_ack = 1; i_mem_rdata = 32'h11112222;
        #1;
        chk("both_ma_done", {31'd0, o_ma_done}, 32'd1);
        chk("both_if_done0", {31'd0, o_if_done}, 32'd0);
        @(negedge i_aclk);
        i_mem_ack = 0; i_ma_req = 0;
        chk("both_idle_gap", {31'd0, o_mem_req}, 32'd0);
        @(negedge i_aclk);
        chk("both_second_addr", o_mem_addr, 32'h180);
        i_mem_ack = 1; i_mem_rdata = 32'h33334444;
        #1;
        chk("both_if_done", {31'd0, o_if_done}, 32'd1);
        @(negedge i_aclk);
        idle_inputs();

        // Streak: continuous data with fetch pending -> D D D D F D.
        i_if_req = 1; i_if_addr = 32'h1F0;
        i_ma_req = 1; i_ma_addr = 32'h4000; i_ma_be = 4'hF;
        for (int g = 0; g < 6; g++) begin
            @(negedge i_aclk);
            chk($sformatf("streak_g%0d_req", g), {31'd0, o_mem_req}, 32'd1);
            chk($sformatf("streak_g%0d_is_fetch", g), {31'd0, o_mem_addr == 32'h1F0},
                {31'd0, g == 4});
            i_mem_ack = 1;
            @(negedge i_aclk);
            i_mem_ack = 0;
            if (g == 4) i_if_req = 0;
            else        i_ma_addr = i_ma_addr + 32'd4;
        end
        idle_inputs();
        @(negedge i_aclk);

        // Flush while IF_BUSY: done suppressed, bus still completes, new address granted next.
        i_if_req = 1; i_if_addr = 32'h200;
        @(negedge i_aclk);
        chk("flush_busy_addr", o_mem_addr, 32'h200);
        i_if_flush = 1; i_if_addr = 32'h240;
        @(negedge i_aclk);
        i_if_flush = 0;
        chk("flush_addr_held", o_mem_addr, 32'h200);
        i_mem_ack = 1;
        #1;
        chk("flush_done_suppressed", {31'd0, o_if_done}, 32'd0);
        @(negedge i_aclk);
        i_mem_ack = 0;
        chk("flush_req_drop", {31'd0, o_mem_req}, 32'd0);
        @(negedge i_aclk);
        chk("flush_new_addr", o_mem_addr, 32'h240);
        i_mem_ack = 1;
        #1;
        chk("flush_new_done", {31'd0, o_if_done}, 32'd1);
        @(negedge i_aclk);
        i_mem_ack = 0; i_if_addr = 32'h280;
        // Flush coinciding with the ack cycle.
        @(negedge i_aclk);
        chk("flush_ack_addr", o_mem_addr, 32'h280);
        i_mem_ack = 1; i_if_flush = 1; i_if_addr = 32'h2C0;
        #1;
        chk("flush_ack_done", {31'd0, o_if_done}, 32'd0);
        @(negedge i_aclk);
        i_mem_ack = 0; i_if_flush = 0;
        @(negedge i_aclk);
        chk("after_flush_addr", o_mem_addr, 32'h2C0);
        i_mem_ack = 1;
        #1;
        chk("after_flush_done", {31'd0, o_if_done}, 32'd1);
        @(negedge i_aclk);
        idle_inputs();

        // Reset in DATA_BUSY followed by a stray ack.
        i_ma_req = 1; i_ma_addr = 32'h5000; i_ma_be = 4'hF;
        @(negedge i_aclk);
        chk("rstmid_busy", {31'd0, o_mem_req}, 32'd1);
        i_reset = 1; i_ma_req = 0;
        @(negedge i_aclk);
        i_reset = 0;
        i_mem_ack = 1;
        #1;
        chk("rstmid_req", {31'd0, o_mem_req}, 32'd0);
        chk("rstmid_ma_done", {31'd0, o_ma_done}, 32'd0);
        chk("rstmid_state", {30'd0, dut.r_state}, {30'd0, ARB_IDLE});
        chk("rstmid_streak", {29'd0, dut.r_streak}, 32'd0);
        @(negedge i_aclk);
        i_mem_ack = 0;
        chk("rstmid_req_after", {31'd0, o_mem_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
